// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and sizing helpers shared by the multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int DEF_WIDTH = 32;
    localparam int CNT_W = $clog2(DEF_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one-bit-per-cycle shift-add multiply / restoring divide datapath on unsigned magnitudes
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_div,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [WIDTH-1:0]     o_rem
);
    localparam int CW = cnt_width(WIDTH);
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_m;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_next;
    // Divide keeps the quotient in the low half of r_acc; the top bit of w_diff is the borrow.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_next  = i_div ? {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], ~w_diff[WIDTH]}
                           : {w_sum, r_acc[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_rem <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, i_a};
            r_m   <= i_b;
            r_rem <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_next;
            r_rem <= i_div ? (w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0]) : r_rem;
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign o_last = r_cnt == CW'(WIDTH - 1);
    assign o_acc  = r_acc;
    assign o_rem  = r_rem;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide with HI/LO registers and MTHI/MTLO writes
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic               r_neg;
    logic               r_neg_a;
    logic               r_bz;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_accept;
    logic               w_signed;
    logic               w_div;
    logic               w_last;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    assign w_accept = start && r_state == IDLE;
    assign w_signed = op == OP_MULT || op == OP_DIV;
    assign w_amag   = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_bmag   = (w_signed && b[WIDTH-1]) ? -b : b;
    assign w_div    = r_op == OP_DIV || r_op == OP_DIVU;
    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_step (r_state == RUN),
        .i_div  (w_div),
        .i_a    (w_amag),
        .i_b    (w_bmag),
        .o_last (w_last),
        .o_acc  (w_acc),
        .o_rem  (w_rem)
    );
    always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
    always_comb begin
        w_next = r_state == IDLE ? (start ? RUN : IDLE)
               : r_state == RUN  ? (w_last ? FIX : RUN)
               : r_state == FIX  ? DONE : IDLE;
    end
    always_comb begin
        busy = r_state != IDLE;
        done = r_state == DONE;
    end
    // Magnitude results are sign-corrected here; a zero divisor overrides them entirely.
    assign w_prod   = r_neg ? -w_acc : w_acc;
    assign w_q      = r_neg ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    assign w_r      = r_neg_a ? -w_rem : w_rem;
    assign w_hi_res = !w_div ? w_prod[2*WIDTH-1:WIDTH] : r_bz ? r_a : w_r;
    assign w_lo_res = !w_div ? w_prod[WIDTH-1:0] : r_bz ? '1 : w_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_MULT;
            r_neg   <= 1'b0;
            r_neg_a <= 1'b0;
            r_bz    <= 1'b0;
            r_dbz   <= 1'b0;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op;
                r_neg   <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_a <= w_signed && a[WIDTH-1];
                r_bz    <= (op == OP_DIV || op == OP_DIVU) && b == '0;
                r_a     <= a;
                r_dbz   <= 1'b0;
            end
            if (r_state == FIX) begin
                r_hi  <= w_hi_res;
                r_lo  <= w_lo_res;
                r_dbz <= r_bz;
            end else begin
                if (hi_wr) r_hi <= wr_data;
                if (lo_wr) r_lo <= wr_data;
            end
        end
    end
    assign div_by_zero = r_dbz;
    assign hi_out      = r_hi;
    assign lo_out      = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random multiply/divide checks against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    int          total = 0;
    int          bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {div_by_zero, HI, LO} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[1] && y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        case (o)
            2'b00: v = sx * sy;
            2'b01: v = {32'b0, x} * {32'b0, y};
            2'b10: begin
                q = sx / sy;
                r = sx % sy;
                v = {r[31:0], q[31:0]};
            end
            default: v = {x % y, x / y};
        endcase
        return {1'b0, v};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [64:0] e;
        int n;
        e = model(o, x, y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_dbz_clr"}, div_by_zero, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 60);
        check({tag, "_latency"}, n, 33);
        check({tag, "_hi"}, hi_out, e[63:32]);
        check({tag, "_lo"}, lo_out, e[31:0]);
        check({tag, "_dbz"}, div_by_zero, e[64]);
        tick();
        check({tag, "_idle"}, {done, busy}, 0);
    endtask

    initial begin
        int seen;
        logic [1:0] ro;
        logic [31:0] ra;
        logic [31:0] rb;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        reset = 1'b0;
        tick();

        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
        check("mult_neg_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, "divu_zero");
        run_op(2'b01, 32'h0000_0003, 32'h0000_0004, "multu_after_dbz");
        run_op(2'b10, 32'h0000_0064, 32'h0000_0000, "div_zero");

        hi_wr = 1'b1;
        wr_data = 32'hA5A5_1234;
        tick();
        hi_wr = 1'b0;
        check("mthi", hi_out, 32'hA5A5_1234);
        lo_wr = 1'b1;
        wr_data = 32'h0BAD_F00D;
        tick();
        lo_wr = 1'b0;
        check("mtlo", lo_out, 32'h0BAD_F00D);

        op = 2'b01;
        a = 32'd5;
        b = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 5) begin
                lo_wr = 1'b1;
                wr_data = 32'h1234_5678;
            end
            if (k == 6) begin
                lo_wr = 1'b0;
                check("mtlo_busy", lo_out, 32'h1234_5678);
            end
            if (k == 10) begin
                start = 1'b1;
                op = 2'b11;
                a = 32'd100;
                b = 32'd3;
            end
            if (k == 11) start = 1'b0;
            if (k == 32) begin
                hi_wr = 1'b1;
                wr_data = 32'hDEAD_BEEF;
            end
            if (k == 33) begin
                hi_wr = 1'b0;
                check("ctl_done", done, 1);
                check("ctl_hi", hi_out, 32'h0);
                check("ctl_lo", lo_out, 32'h1E);
            end
            if (k == 34) check("ctl_busy_end", busy, 0);
        end

        op = 2'b00;
        a = 32'd1234;
        b = 32'd5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi_out, 0);
        check("rst_mid_lo", lo_out, 0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) seen++;
        end
        check("rst_mid_no_done", seen, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom_range(0, 5) == 0 ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with integrated HI/LO registers, replacing the separate fixed-width multiplier, divider and HI/LO blocks in the multicycle CPU datapath. It performs signed/unsigned radix-2 multiplication and restoring division, one bit per cycle, under a start/busy/done handshake driven by the control unit. It also takes direct HI/LO writes for MTHI/MTLO.

## Interface
- WIDTH, 32: operand width; HI/LO are each WIDTH bits; must be ≥ 4 and even.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on clk rising edge.
- start  in  1  request; accepted only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- hi_wr  in  1  load hi_out from wr_data (MTHI).
- lo_wr  in  1  load lo_out from wr_data (MTLO).
- wr_data  in  WIDTH  data for hi_wr/lo_wr.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; HI/LO hold the new result while it is high.
- div_by_zero  out  1  set with done for DIV/DIVU with b = 0; cleared on the next accepted start.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE→RUN on start.
  - RUN→FIX after WIDTH iterations.
  - FIX→DONE unconditionally.
  - DONE→IDLE unconditionally.
- On accept:
  - Latch op.
  - For signed ops, latch |a| and |b| and the result signs; otherwise latch a and b raw.
  - Clear the iteration counter and div_by_zero.
- Multiply, RUN: shift-add on a 2·WIDTH accumulator. FIX negates the product if sign(a) ≠ sign(b) for MULT. HI = upper WIDTH bits, LO = lower.
- Divide, RUN: restoring division with a (WIDTH+1)-bit partial remainder.
- Divide, FIX sign rules:
  - Quotient is negated if the signs differ; quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Results: LO = quotient, HI = remainder.
- Signed overflow: DIV of MIN by −1 gives LO = MIN, HI = 0. This is natural magnitude-path behaviour; no trap.
- Divide by zero:
  - Iteration still runs full length, so latency is constant.
  - FIX forces LO = all ones and HI = original a.
  - div_by_zero is raised.
- Result write: FIX writes hi_out/lo_out at the FIX→DONE edge.
- hi_wr/lo_wr:
  - Applied in any state.
  - If the FIX write edge coincides with hi_wr/lo_wr, the FIX write wins and the direct write is dropped.
- start while busy (including DONE) is ignored; operands are not re-sampled.

## Timing
- Reset values: state IDLE, busy 0, done 0, div_by_zero 0, hi_out 0, lo_out 0, counter 0.
- Reset mid-operation: returns to IDLE next edge, clears HI/LO, and produces no done pulse.
- Latency, with start sampled at edge E0:
  - busy is high from after E0 until after E(WIDTH+2).
  - HI/LO update at E(WIDTH+1).
  - done is high for exactly the cycle between E(WIDTH+1) and E(WIDTH+2).
- WIDTH=32: done appears 33 edges after the start edge, and busy is high for 34 cycles.
- Back-to-back: a new start is accepted at the edge where the unit is in IDLE. The earliest is E(WIDTH+3) when start is held high continuously.
- hi_wr/lo_wr take effect at the sampling edge and are visible on hi_out/lo_out the next cycle.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - the state enum: IDLE, RUN, FIX, DONE.
  - localparam CNT_W = $clog2(WIDTH+1).
- One sub-module, muldiv_core, holds the iteration datapath: accumulator/remainder registers, counter, and the shift-add/restoring step.
- The top holds the FSM, sign handling, FIX correction, HI/LO registers and the direct-write arbitration.

## Test plan
For all scenarios, WIDTH = 32.
- MULT a=FFFFFFFD (−3), b=00000007 → done at edge 33 with HI=FFFFFFFF, LO=FFFFFFEB.
- MULTU a=b=FFFFFFFF → HI=FFFFFFFE, LO=00000001; div_by_zero 0.
- DIV a=FFFFFFF9 (−7), b=00000002 → LO=FFFFFFFD, HI=FFFFFFFF.
- DIV a=80000000, b=FFFFFFFF → LO=80000000, HI=00000000.
- DIVU a=00000007, b=0 → done with div_by_zero=1, HI=00000007, LO=FFFFFFFF.
  - Next MULTU start clears div_by_zero.
- Control/reset sequence:
  - Start MULTU 5×6; pulse start again with other operands at cycle 10 → ignored, result HI=0, LO=0000001E.
  - hi_wr coinciding with the FIX edge is dropped.
  - reset asserted at cycle 15 of a new operation → IDLE, HI=LO=0, no done.
